memchip_burst: RTL and testbench

Parametrised, clocked successor of the 64-word memory chip. One ROM region and `N_BANKS` equally sized RAM banks sit behind a single valid/ready request port and a back-pressurable response port. Incrementing read bursts and error reporting for unmapped or ROM-write accesses are supported. The block sits between a bus master (CPU/test sequencer) and the memory map, replacing the tri-state shared-`out` organisation with a muxed, registered response.

---
 rtl/memchip_pkg.sv | 41 ++++
 rtl/mem_bank.sv | 25 ++
 rtl/memchip_burst.sv | 177 +++++++++++++++++
 tb/tb_memchip_burst.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/memchip_pkg.sv
// Shared types and helpers for the burst memory chip: FSM states, response
// source select, region decode and ROM contents.
package memchip_pkg;

  typedef enum logic [1:0] {StIdle, StRead, StWresp} state_e;

  typedef enum logic [1:0] {SelNone, SelRom, SelBank} rsp_sel_e;

  typedef struct packed {
    logic       hit_rom;
    logic       hit_bank;
    logic [7:0] bank_idx;
    logic       err;
  } dec_t;

  // ROM wins over any bank that overlaps it; first matching bank wins otherwise.
  function automatic dec_t region_decode(input int unsigned addr, input int unsigned rom_depth,
                                         input int unsigned n_banks, input int unsigned bank_depth,
                                         input int unsigned ram_base, input int unsigned stride);
    dec_t d;
    d = '0;
    if (addr < rom_depth) begin
      d.hit_rom = 1'b1;
    end else begin
      for (int unsigned k = 0; k < n_banks; k++) begin
        if (!d.hit_bank && addr >= ram_base + k * stride &&
            addr < ram_base + k * stride + bank_depth) begin
          d.hit_bank = 1'b1;
          d.bank_idx = 8'(k);
        end
      end
    end
    d.err = !(d.hit_rom || d.hit_bank);
    return d;
  endfunction

  function automatic logic [63:0] rom_word(input int unsigned idx);
    return ~64'(idx);
  endfunction

endpackage

// File: rtl/mem_bank.sv
// Single-port synchronous RAM bank, read-first, contents not reset.
module mem_bank #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned BANK_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(BANK_DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]             wdata,
  output logic [DATA_W-1:0]             rdata
);

  logic [DATA_W-1:0] mem_q [BANK_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/memchip_burst.sv
// ROM plus N RAM banks behind a valid/ready request port with incrementing read
// bursts and a registered, back-pressurable response.
module memchip_burst
  import memchip_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned LEN_W       = 3,
  parameter int unsigned ROM_DEPTH   = 16,
  parameter int unsigned N_BANKS     = 2,
  parameter int unsigned BANK_DEPTH  = 8,
  parameter int unsigned RAM_BASE    = 16,
  parameter int unsigned BANK_STRIDE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rsp_last
);

  localparam int unsigned BankAw   = $clog2(BANK_DEPTH);
  localparam int unsigned BankIdxW = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 rsp_last_q, rsp_last_d;
  rsp_sel_e             sel_q, sel_d;
  logic [BankIdxW-1:0]  bank_idx_q, bank_idx_d;
  logic [DATA_W-1:0]    rom_data_q, rom_data_d;

  dec_t                 dec_nxt;
  logic                 accept, write_acc, load_beat;
  logic [BankAw-1:0]    bank_addr;
  logic [N_BANKS-1:0]   bank_we;
  logic [DATA_W-1:0]    bank_rdata [N_BANKS];

  assign req_ready = rst_n && (state_q == StIdle);
  assign accept    = req_valid && req_ready;
  assign write_acc = accept && req_rw;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_last_d  = rsp_last_q;
    sel_d       = sel_q;
    bank_idx_d  = bank_idx_q;
    rom_data_d  = rom_data_q;
    load_beat   = 1'b0;

    unique case (state_q)
      StIdle: begin
        addr_d = req_addr;
        if (accept) begin
          rsp_valid_d = 1'b1;
          if (req_rw) begin
            state_d    = StWresp;
            rsp_last_d = 1'b1;
            sel_d      = SelNone;
          end else begin
            state_d    = StRead;
            cnt_d      = req_len;
            rsp_last_d = (req_len == '0);
            load_beat  = 1'b1;
          end
        end
      end
      StRead: begin
        if (rsp_ready) begin
          if (cnt_q == '0) begin
            state_d     = StIdle;
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
            rsp_last_d  = 1'b0;
            sel_d       = SelNone;
          end else begin
            addr_d     = addr_q + ADDR_W'(1);
            cnt_d      = cnt_q - LEN_W'(1);
            rsp_last_d = (cnt_q == LEN_W'(1));
            load_beat  = 1'b1;
          end
        end
      end
      StWresp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_last_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // addr_d is the word the banks see this edge: request address or next beat.
    dec_nxt = region_decode(32'(addr_d), ROM_DEPTH, N_BANKS, BANK_DEPTH, RAM_BASE, BANK_STRIDE);

    if (write_acc) begin
      rsp_err_d = !dec_nxt.hit_bank;
    end
    if (load_beat) begin
      rsp_err_d  = dec_nxt.err;
      sel_d      = dec_nxt.hit_rom ? SelRom : (dec_nxt.hit_bank ? SelBank : SelNone);
      bank_idx_d = BankIdxW'(dec_nxt.bank_idx);
      rom_data_d = DATA_W'(rom_word(32'(addr_d)));
    end
  end

  assign bank_addr = BankAw'(32'(addr_d) - RAM_BASE - 32'(dec_nxt.bank_idx) * BANK_STRIDE);

  for (genvar k = 0; k < N_BANKS; k++) begin : g_bank
    assign bank_we[k] = write_acc && dec_nxt.hit_bank && (dec_nxt.bank_idx == 8'(k));

    mem_bank #(
      .DATA_W     (DATA_W),
      .BANK_DEPTH (BANK_DEPTH)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[k]),
      .addr  (bank_addr),
      .wdata (req_wdata),
      .rdata (bank_rdata[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_last_q  <= 1'b0;
      sel_q       <= SelNone;
      bank_idx_q  <= '0;
      rom_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_last_q  <= rsp_last_d;
      sel_q       <= sel_d;
      bank_idx_q  <= bank_idx_d;
      rom_data_q  <= rom_data_d;
    end
  end

  always_comb begin
    rsp_data = '0;
    unique case (sel_q)
      SelRom:  rsp_data = rom_data_q;
      SelBank: rsp_data = bank_rdata[bank_idx_q];
      default: rsp_data = '0;
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_memchip_burst.sv
// Bench for memchip_burst: directed scenarios plus random traffic against an
// address-map reference model.
module tb_memchip_burst;

  localparam int DataW = 16, AddrW = 6, LenW = 3;
  localparam int RomDepth = 16, NBanks = 2, BankDepth = 8, RamBase = 16, Stride = 16;
  localparam int Words = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid, req_ready, req_rw;
  logic [AddrW-1:0] req_addr;
  logic [LenW-1:0]  req_len;
  logic [DataW-1:0] req_wdata;
  logic             rsp_valid, rsp_ready, rsp_err, rsp_last;
  logic [DataW-1:0] rsp_data;

  int checks = 0;
  int failures = 0;
  logic [DataW-1:0] ram_model [Words];

  always #5 clk = ~clk;

  memchip_burst dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_last  (rsp_last)
  );

  function automatic bit is_rom(int a);
    return a < RomDepth;
  endfunction

  function automatic bit is_ram(int a);
    if (is_rom(a) || a < RamBase) return 1'b0;
    return ((a - RamBase) % Stride < BankDepth) && ((a - RamBase) / Stride < NBanks);
  endfunction

  function automatic logic [DataW-1:0] exp_word(int a);
    logic [DataW-1:0] v;
    if (is_rom(a)) begin
      v = DataW'(a);
      return ~v;
    end
    if (is_ram(a)) return ram_model[a];
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic pick_ready(bit use_pat, logic [15:0] pat, int cyc, int stalls);
    if (use_pat) return pat[cyc];
    if (stalls >= 3) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_write(input int a, input logic [DataW-1:0] d);
    int cyc, stalls;
    bit done;
    logic rdy;
    @(posedge clk); #1;
    req_valid = 1'b1; req_rw = 1'b1; req_addr = AddrW'(a); req_wdata = d;
    req_len = LenW'($urandom);
    @(negedge clk);
    chk("wr_req_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (is_ram(a)) ram_model[a] = d;
    cyc = 0; stalls = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      rdy = pick_ready(1'b0, 16'h0, cyc, stalls);
      rsp_ready = rdy;
      @(negedge clk);
      chk("wr_valid", rsp_valid, 1);
      chk("wr_last", rsp_last, 1);
      chk("wr_data", rsp_data, 0);
      chk("wr_err", rsp_err, !is_ram(a));
      @(posedge clk); #1;
      if (rdy) done = 1'b1; else stalls++;
      cyc++;
    end
    if (!done) chk("wr_timeout", 0, 1);
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("wr_idle_valid", rsp_valid, 0);
    chk("wr_idle_ready", req_ready, 1);
  endtask

  task automatic do_read(input int a0, input int len, input bit use_pat, input logic [15:0] pat);
    int cyc, stalls, beat, a;
    logic rdy;
    @(posedge clk); #1;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = AddrW'(a0); req_len = LenW'(len);
    req_wdata = DataW'($urandom);
    @(negedge clk);
    chk("rd_req_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0; stalls = 0; beat = 0; a = a0;
    while (beat <= len && cyc < 100) begin
      rdy = pick_ready(use_pat, pat, cyc, stalls);
      rsp_ready = rdy;
      @(negedge clk);
      chk("rd_valid", rsp_valid, 1);
      chk("rd_data", rsp_data, exp_word(a));
      chk("rd_err", rsp_err, !(is_rom(a) || is_ram(a)));
      chk("rd_last", rsp_last, beat == len);
      chk("rd_busy_ready", req_ready, 0);
      @(posedge clk); #1;
      if (rdy) begin
        beat++;
        a = (a + 1) % Words;
        stalls = 0;
      end else begin
        stalls++;
      end
      cyc++;
    end
    if (beat <= len) chk("rd_timeout", beat, len + 1);
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("rd_idle_valid", rsp_valid, 0);
    chk("rd_idle_ready", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_len = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_last", rsp_last, 0);
    chk("rst_data", rsp_data, 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);

    // Single ROM word read: ~5.
    do_read(5, 0, 1'b1, 16'h0001);

    // Fill every bank word so later reads have defined contents.
    for (int a = 0; a < Words; a++) begin
      if (is_ram(a)) do_write(a, DataW'($urandom));
    end

    // Bank separation and read-after-write.
    do_write(8'h12, 16'hBEEF);
    do_write(8'h21, 16'h1234);
    do_read(8'h12, 0, 1'b0, 16'h0);
    do_read(8'h21, 0, 1'b0, 16'h0);
    chk("model_12", ram_model[8'h12], 16'hBEEF);

    // ROM write is rejected and leaves the ROM word intact.
    do_write(8'h03, 16'hAAAA);
    do_read(8'h03, 0, 1'b0, 16'h0);

    // ROM-to-bank burst with the ready pattern 1,0,1,1,0,1.
    do_read(8'h0E, 3, 1'b1, 16'b10_1101);

    // Unmapped beats then address wrap to the ROM.
    do_read(8'h3E, 2, 1'b1, 16'hFFFF);

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_write(int'($urandom_range(0, Words - 1)), DataW'($urandom));
      end else begin
        do_read(int'($urandom_range(0, Words - 1)), int'($urandom_range(0, 7)), 1'b0, 16'h0);
      end
    end

    // Reset during beat 1 of an 8-beat burst.
    @(posedge clk); #1;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = '0; req_len = 3'd7;
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("abort_beat0", rsp_data, 16'hFFFF);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_beat1", rsp_data, 16'hFFFE);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_valid", rsp_valid, 0);
    chk("abort_rst_ready", req_ready, 0);
    rst_n = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_release_ready", req_ready, 1);
    chk("abort_release_valid", rsp_valid, 0);

    // Banks keep their contents across reset.
    do_read(8'h12, 0, 1'b0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
